// File: rtl/mastermind_pkg.sv
// Shared parameters and types for the Mastermind scoring datapath.
package mastermind_pkg;
   localparam int COLOUR_W    = 3;
   localparam int NUM_COLOURS = 6;
   localparam int MAX_GUESSES = 10;
   localparam int NUM_PEGS    = 4;
   localparam int GUESS_CNT_W = $clog2(MAX_GUESSES + 1);

   typedef logic [COLOUR_W-1:0] colour_t;
   typedef logic [2:0]          peg_cnt_t;

   localparam peg_cnt_t                 PEG_MAX  = 3'd4;
   localparam logic [GUESS_CNT_W-1:0]   MAX_CNT  = GUESS_CNT_W'(MAX_GUESSES);
   localparam logic [GUESS_CNT_W-1:0]   LAST_CNT = GUESS_CNT_W'(MAX_GUESSES - 1);

   function automatic peg_cnt_t min_cnt(input peg_cnt_t a, input peg_cnt_t b);
      return (a < b) ? a : b;
   endfunction
endpackage

// File: rtl/score_datapath_colour_histogram.sv
// Per-colour occurrence counters for one side (code or guess) of the compare.
// Colours outside 0..NUM_COLOURS-1 never match a counter and are therefore dropped.
module colour_histogram
   import mastermind_pkg::*;
(
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          clear,
   input  logic                          inc,
   input  colour_t                       colour,
   output peg_cnt_t [NUM_COLOURS-1:0]    cnt
);

   peg_cnt_t [NUM_COLOURS-1:0] cnt_q;
   peg_cnt_t [NUM_COLOURS-1:0] cnt_d;

   // Next count: clear restarts the tally, including the peg presented in the same cycle.
   always_comb begin
      cnt_d = cnt_q;
      for (int c = 0; c < NUM_COLOURS; c++) begin
         if (clear) begin
            cnt_d[c] = (inc && (colour == colour_t'(c))) ? 3'd1 : 3'd0;
         end else if (inc && (colour == colour_t'(c)) && (cnt_q[c] != PEG_MAX)) begin
            cnt_d[c] = cnt_q[c] + 3'd1;
         end else begin
            cnt_d[c] = cnt_q[c];
         end
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt = cnt_q;

endmodule

// File: rtl/score_datapath.sv
// Mastermind scoring datapath: peg storage, per-position compare, black/white
// reduction and sticky win/lose status for the game control FSM.
module score_datapath
   import mastermind_pkg::*;
(
   input  logic                   clk,
   input  logic                   reset,
   input  colour_t                data_in,
   input  logic                   load_code_1,
   input  logic                   load_code_2,
   input  logic                   load_code_3,
   input  logic                   load_code_4,
   input  logic                   load_guess_1,
   input  logic                   load_guess_2,
   input  logic                   load_guess_3,
   input  logic                   load_guess_4,
   input  logic                   compare,
   input  logic [1:0]             compare_i,
   input  logic                   reach_result_4,
   output peg_cnt_t               black_pegs,
   output peg_cnt_t               white_pegs,
   output logic                   result_valid,
   output logic [GUESS_CNT_W-1:0] guess_count,
   output logic                   win,
   output logic                   lose
);

   logic [NUM_PEGS-1:0] ld_code_s;
   logic [NUM_PEGS-1:0] ld_guess_s;
   colour_t [NUM_PEGS-1:0] code_q, code_d;
   colour_t [NUM_PEGS-1:0] guess_q, guess_d;
   logic load_code_1_q;

   peg_cnt_t black_acc_q, black_acc_d;
   peg_cnt_t black_q, black_d;
   peg_cnt_t white_q, white_d;
   logic     result_valid_q, result_valid_d;
   logic [GUESS_CNT_W-1:0] count_q, count_d;
   logic     win_q, win_d;
   logic     lose_q, lose_d;

   logic     new_game_s, game_over_s, do_cmp_s, do_final_s, hist_clear_s, exact_s;
   colour_t  cmp_code_s, cmp_guess_s;
   peg_cnt_t [NUM_COLOURS-1:0] code_cnt_s;
   peg_cnt_t [NUM_COLOURS-1:0] guess_cnt_s;
   logic [4:0] matches_s;
   logic [4:0] diff_s;
   peg_cnt_t   white_calc_s;

   assign ld_code_s  = {load_code_4, load_code_3, load_code_2, load_code_1};
   assign ld_guess_s = {load_guess_4, load_guess_3, load_guess_2, load_guess_1};

   assign new_game_s   = load_code_1 & ~load_code_1_q;
   assign game_over_s  = win_q | lose_q;
   // reach_result_4 wins over a simultaneous (illegal) compare.
   assign do_cmp_s     = compare & ~reach_result_4 & ~game_over_s;
   assign do_final_s   = reach_result_4 & ~game_over_s & ~new_game_s;
   assign hist_clear_s = do_cmp_s & (compare_i == 2'd0);

   assign cmp_code_s  = code_q[compare_i];
   assign cmp_guess_s = guess_q[compare_i];
   assign exact_s     = (cmp_code_s == cmp_guess_s) && (cmp_guess_s < colour_t'(NUM_COLOURS));

   // Peg registers follow their level enables independently of game state.
   always_comb begin
      code_d  = code_q;
      guess_d = guess_q;
      for (int i = 0; i < NUM_PEGS; i++) begin
         code_d[i]  = ld_code_s[i]  ? data_in : code_q[i];
         guess_d[i] = ld_guess_s[i] ? data_in : guess_q[i];
      end
   end

   colour_histogram u_code_hist (
      .clk    (clk),
      .reset  (reset),
      .clear  (hist_clear_s),
      .inc    (do_cmp_s),
      .colour (cmp_code_s),
      .cnt    (code_cnt_s)
   );

   colour_histogram u_guess_hist (
      .clk    (clk),
      .reset  (reset),
      .clear  (hist_clear_s),
      .inc    (do_cmp_s),
      .colour (cmp_guess_s),
      .cnt    (guess_cnt_s)
   );

   // Exact-match accumulator, restarted by index 0.
   always_comb begin
      if (!do_cmp_s) begin
         black_acc_d = black_acc_q;
      end else if (compare_i == 2'd0) begin
         black_acc_d = exact_s ? 3'd1 : 3'd0;
      end else if (exact_s && (black_acc_q != PEG_MAX)) begin
         black_acc_d = black_acc_q + 3'd1;
      end else begin
         black_acc_d = black_acc_q;
      end
   end

   // Colour matches irrespective of position; white is what is left after blacks.
   always_comb begin
      matches_s = 5'd0;
      for (int c = 0; c < NUM_COLOURS; c++) begin
         matches_s = matches_s + 5'(min_cnt(code_cnt_s[c], guess_cnt_s[c]));
      end
      diff_s = matches_s - {2'b00, black_acc_q};
      if (matches_s <= {2'b00, black_acc_q}) begin
         white_calc_s = 3'd0;
      end else if (diff_s > 5'd4) begin
         white_calc_s = PEG_MAX;
      end else begin
         white_calc_s = diff_s[2:0];
      end
   end

   // Result and status update: a new game clears, finalise publishes the score.
   always_comb begin
      result_valid_d = 1'b0;
      if (new_game_s) begin
         black_d = 3'd0;
         white_d = 3'd0;
         count_d = '0;
         win_d   = 1'b0;
         lose_d  = 1'b0;
      end else if (do_final_s) begin
         black_d        = black_acc_q;
         white_d        = white_calc_s;
         result_valid_d = 1'b1;
         count_d        = (count_q == MAX_CNT) ? count_q : count_q + 1'b1;
         if (black_acc_q == PEG_MAX) begin
            win_d  = 1'b1;
            lose_d = lose_q;
         end else if (count_q == LAST_CNT) begin
            win_d  = win_q;
            lose_d = 1'b1;
         end else begin
            win_d  = win_q;
            lose_d = lose_q;
         end
      end else begin
         black_d = black_q;
         white_d = white_q;
         count_d = count_q;
         win_d   = win_q;
         lose_d  = lose_q;
      end
   end

   // State registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         code_q         <= '0;
         guess_q        <= '0;
         load_code_1_q  <= 1'b0;
         black_acc_q    <= 3'd0;
         black_q        <= 3'd0;
         white_q        <= 3'd0;
         result_valid_q <= 1'b0;
         count_q        <= '0;
         win_q          <= 1'b0;
         lose_q         <= 1'b0;
      end else begin
         code_q         <= code_d;
         guess_q        <= guess_d;
         load_code_1_q  <= load_code_1;
         black_acc_q    <= black_acc_d;
         black_q        <= black_d;
         white_q        <= white_d;
         result_valid_q <= result_valid_d;
         count_q        <= count_d;
         win_q          <= win_d;
         lose_q         <= lose_d;
      end
   end

   assign black_pegs   = black_q;
   assign white_pegs   = white_q;
   assign result_valid = result_valid_q;
   assign guess_count  = count_q;
   assign win          = win_q;
   assign lose         = lose_q;

endmodule

// File: tb/tb_score_datapath.sv
// Self-checking bench for score_datapath against a counting-based Mastermind model.
module tb_score_datapath;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [2:0] data_in = 3'd0;
   logic       load_code_1 = 1'b0, load_code_2 = 1'b0, load_code_3 = 1'b0, load_code_4 = 1'b0;
   logic       load_guess_1 = 1'b0, load_guess_2 = 1'b0, load_guess_3 = 1'b0, load_guess_4 = 1'b0;
   logic       compare = 1'b0;
   logic [1:0] compare_i = 2'd0;
   logic       reach_result_4 = 1'b0;
   logic [2:0] black_pegs, white_pegs;
   logic       result_valid;
   logic [3:0] guess_count;
   logic       win, lose;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference game state
   int m_code[4];
   int m_guess[4];
   int m_black = 0, m_white = 0, m_count = 0;
   bit m_win = 0, m_lose = 0;

   score_datapath dut (
      .clk(clk), .reset(reset), .data_in(data_in),
      .load_code_1(load_code_1), .load_code_2(load_code_2),
      .load_code_3(load_code_3), .load_code_4(load_code_4),
      .load_guess_1(load_guess_1), .load_guess_2(load_guess_2),
      .load_guess_3(load_guess_3), .load_guess_4(load_guess_4),
      .compare(compare), .compare_i(compare_i), .reach_result_4(reach_result_4),
      .black_pegs(black_pegs), .white_pegs(white_pegs), .result_valid(result_valid),
      .guess_count(guess_count), .win(win), .lose(lose)
   );

   always #5 clk = ~clk;

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   // Mastermind scoring by colour counting; colours 6 and 7 never score.
   task automatic ref_score(output int b, output int w);
      int hc[8];
      int hg[8];
      int m;
      b = 0; m = 0;
      for (int c = 0; c < 8; c++) begin hc[c] = 0; hg[c] = 0; end
      for (int p = 0; p < 4; p++) begin
         if (m_guess[p] < 6 && m_guess[p] == m_code[p]) b++;
         if (m_code[p] < 6) hc[m_code[p]]++;
         if (m_guess[p] < 6) hg[m_guess[p]]++;
      end
      for (int c = 0; c < 6; c++) m += (hc[c] < hg[c]) ? hc[c] : hg[c];
      w = m - b;
   endtask

   task automatic load_code(input int c0, input int c1, input int c2, input int c3);
      m_code[0] = c0; m_code[1] = c1; m_code[2] = c2; m_code[3] = c3;
      data_in = 3'(c0); load_code_1 = 1'b1; cyc(); load_code_1 = 1'b0;
      data_in = 3'(c1); load_code_2 = 1'b1; cyc(); load_code_2 = 1'b0;
      data_in = 3'(c2); load_code_3 = 1'b1; cyc(); load_code_3 = 1'b0;
      data_in = 3'(c3); load_code_4 = 1'b1; cyc(); load_code_4 = 1'b0;
      m_count = 0; m_win = 0; m_lose = 0; m_black = 0; m_white = 0;
   endtask

   task automatic load_guess(input int g0, input int g1, input int g2, input int g3);
      m_guess[0] = g0; m_guess[1] = g1; m_guess[2] = g2; m_guess[3] = g3;
      data_in = 3'(g0); load_guess_1 = 1'b1; cyc(); load_guess_1 = 1'b0;
      data_in = 3'(g1); load_guess_2 = 1'b1; cyc(); load_guess_2 = 1'b0;
      data_in = 3'(g2); load_guess_3 = 1'b1; cyc(); load_guess_3 = 1'b0;
      data_in = 3'(g3); load_guess_4 = 1'b1; cyc(); load_guess_4 = 1'b0;
   endtask

   // Runs the four compare cycles plus finalise and checks the published result.
   task automatic score_and_check(input string name);
      int b, w;
      bit exp_rv;
      for (int i = 0; i < 4; i++) begin
         compare = 1'b1; compare_i = 2'(i); cyc();
      end
      compare = 1'b0;
      reach_result_4 = 1'b1; cyc(); reach_result_4 = 1'b0;
      exp_rv = !(m_win || m_lose);
      if (exp_rv) begin
         ref_score(b, w);
         m_black = b; m_white = w;
         if (m_count < 10) m_count++;
         if (b == 4) m_win = 1;
         else if (m_count == 10) m_lose = 1;
      end
      n_cmp++;
      if (result_valid !== exp_rv) begin
         n_bad++; $display("FAIL %s rv: got %0b want %0b", name, result_valid, exp_rv);
      end
      n_cmp++;
      if (black_pegs !== 3'(m_black) || white_pegs !== 3'(m_white)) begin
         n_bad++; $display("FAIL %s pegs: got %0d/%0d want %0d/%0d", name, black_pegs, white_pegs, m_black, m_white);
      end
      n_cmp++;
      if (guess_count !== 4'(m_count) || win !== m_win || lose !== m_lose) begin
         n_bad++; $display("FAIL %s status: got cnt=%0d win=%0b lose=%0b want cnt=%0d win=%0b lose=%0b",
                           name, guess_count, win, lose, m_count, m_win, m_lose);
      end
      cyc();
      n_cmp++;
      if (result_valid !== 1'b0) begin
         n_bad++; $display("FAIL %s rv_pulse: got %0b want 0", name, result_valid);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1; cyc(); cyc(); reset = 1'b0;
      n_cmp++;
      if ({black_pegs, white_pegs, result_valid, guess_count, win, lose} !== 12'd0) begin
         n_bad++; $display("FAIL reset: got b=%0d w=%0d rv=%0b cnt=%0d win=%0b lose=%0b want all 0",
                           black_pegs, white_pegs, result_valid, guess_count, win, lose);
      end
   endtask

   task automatic test_exact_win();
      load_code(1, 2, 3, 4);
      load_guess(1, 2, 3, 4);
      score_and_check("exact_win");
   endtask

   task automatic test_permutation();
      load_code(1, 2, 3, 4);
      load_guess(4, 3, 2, 1);
      score_and_check("permutation");
   endtask

   task automatic test_duplicates_invalid();
      load_code(1, 1, 2, 2);
      load_guess(1, 2, 1, 5);
      score_and_check("duplicates");
      load_guess(6, 7, 6, 7);
      score_and_check("invalid_guess");
      // All four guess enables at once
      data_in = 3'd2;
      {load_guess_1, load_guess_2, load_guess_3, load_guess_4} = 4'hF;
      cyc();
      {load_guess_1, load_guess_2, load_guess_3, load_guess_4} = 4'h0;
      for (int p = 0; p < 4; p++) m_guess[p] = 2;
      score_and_check("simultaneous_load");
   endtask

   task automatic test_lose();
      load_code(0, 5, 3, 3);
      for (int g = 0; g < 10; g++) begin
         load_guess(int'($urandom_range(1, 7)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         score_and_check($sformatf("lose_g%0d", g));
      end
      load_guess(0, 5, 3, 3);
      score_and_check("after_lose_ignored");
   endtask

   task automatic test_reset_mid();
      load_code(2, 2, 4, 0);
      load_guess(2, 2, 4, 0);
      compare = 1'b1;
      compare_i = 2'd0; cyc();
      compare_i = 2'd1; cyc();
      compare_i = 2'd2; reset = 1'b1; cyc();
      compare = 1'b0; reset = 1'b0;
      n_cmp++;
      if ({black_pegs, white_pegs, result_valid, guess_count, win, lose} !== 12'd0) begin
         n_bad++; $display("FAIL reset_mid: got b=%0d w=%0d rv=%0b cnt=%0d win=%0b lose=%0b want all 0",
                           black_pegs, white_pegs, result_valid, guess_count, win, lose);
      end
      reach_result_4 = 1'b0; cyc();
      n_cmp++;
      if (result_valid !== 1'b0) begin
         n_bad++; $display("FAIL reset_mid_rv: got %0b want 0", result_valid);
      end
      m_count = 0; m_win = 0; m_lose = 0; m_black = 0; m_white = 0;
      for (int p = 0; p < 4; p++) begin m_code[p] = 0; m_guess[p] = 0; end
   endtask

   task automatic test_new_game();
      load_code(5, 0, 3, 2);
      load_guess(5, 0, 3, 2);
      score_and_check("pre_new_game_win");
      load_code(1, 4, 4, 0);
      n_cmp++;
      if (win !== 1'b0 || lose !== 1'b0 || guess_count !== 4'd0 || black_pegs !== 3'd0 || white_pegs !== 3'd0) begin
         n_bad++; $display("FAIL new_game: got win=%0b lose=%0b cnt=%0d b=%0d w=%0d want all 0",
                           win, lose, guess_count, black_pegs, white_pegs);
      end
      load_guess(0, 1, 4, 4);
      score_and_check("new_game_score");
   endtask

   task automatic test_random();
      for (int g = 0; g < 25; g++) begin
         load_code(int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
                   int'($urandom_range(0, 5)), int'($urandom_range(0, 5)));
         for (int k = 0; k < 4; k++) begin
            if ($urandom_range(0, 5) == 0)
               load_guess(m_code[0], m_code[1], m_code[2], m_code[3]);
            else
               load_guess(int'($urandom_range(0, 7)), int'($urandom_range(0, 5)),
                          int'($urandom_range(0, 5)), int'($urandom_range(0, 7)));
            score_and_check($sformatf("random_%0d_%0d", g, k));
         end
      end
   endtask

   initial begin
      test_reset();
      test_exact_win();
      test_permutation();
      test_duplicates_invalid();
      test_lose();
      test_reset_mid();
      test_new_game();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
